// File: rtl/mul_rr_scheduler.sv
// mul_rr_scheduler: round-robin arbiter sharing one multi-cycle signed multiplier
// among NUM_REQ requesters, with a watchdog that aborts a hung multiply.
module mul_rr_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int IW            = $clog2(NUM_REQ),
    localparam int WW            = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    output logic                       mul_start,
    input  logic                       mul_done,
    input  logic [2*WIDTH-1:0]         mul_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IW-1:0]              rsp_id,
    output logic [2*WIDTH-1:0]         rsp_result,
    output logic                       rsp_err,
    output logic                       timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    state_t             state_q, state_d;
    logic [IW-1:0]      last_q, last_d, id_q, id_d, gnt, idx;
    logic               found;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WW-1:0]      wd_q, wd_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               err_q, err_d, terr_q, terr_d;

    // Scan downward so the index closest after last_q is the one left in gnt.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_q) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        wd_d    = wd_q;
        res_d   = res_q;
        err_d   = err_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = ISSUE;
                last_d  = gnt;
                id_d    = gnt;
                a_d     = req_a[gnt*WIDTH +: WIDTH];
                b_d     = req_b[gnt*WIDTH +: WIDTH];
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: if (mul_done) begin
                res_d   = mul_result;
                err_d   = 1'b0;
                state_d = RESP;
            end else begin
                wd_d = wd_q + 1'b1;
                if (wd_d == WW'(TIMEOUT_CYCLES)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    terr_d  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            wd_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wd_q    <= wd_d;
            res_q   <= res_d;
            err_q   <= err_d;
            terr_q  <= terr_d;
        end
    end

    assign req_ready   = (state_q == IDLE && found) ? ONE << gnt : '0;
    assign mul_start   = state_q == ISSUE;
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign rsp_valid   = state_q == RESP;
    assign rsp_id      = id_q;
    assign rsp_result  = res_q;
    assign rsp_err     = err_q;
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_mul_rr_scheduler.sv
// tb_mul_rr_scheduler: directed, table-driven bench for mul_rr_scheduler with a
// behavioural multiplier whose latency can be set per operation or disabled.
module tb_mul_rr_scheduler;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_start, mul_done;
    logic [2*W-1:0] mul_result;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_id;
    logic [2*W-1:0] rsp_result;
    logic           rsp_err, timeout_err;

    int n_chk = 0;
    int n_fail = 0;
    int starts = 0;
    int model_lat = 16;
    bit model_en = 1'b1;

    mul_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
        .mul_start(mul_start), .mul_done(mul_done), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mul_start) starts++;

    // Multiplier model: done is raised in the model_lat-th cycle, counting the start cycle as 1.
    initial begin
        logic signed [63:0] pa, pb;
        mul_done = 1'b0;
        mul_result = '0;
        forever begin
            @(negedge clk);
            if (mul_start && model_en) begin
                pa = $signed(mul_a);
                pb = $signed(mul_b);
                repeat (model_lat - 1) @(negedge clk);
                mul_done = 1'b1;
                mul_result = pa * pb;
                @(negedge clk);
                mul_done = 1'b0;
                mul_result = '0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input bit en, input bit exp_err);
        int n, s0;
        @(posedge clk); #1;
        model_lat = lat;
        model_en = en;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid = 4'(1) << id;
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == 0 && n < 20);
        s0 = starts;
        chk("grant", req_ready, 4'(1) << id);
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 200);
        chk("rsp latency", n, en ? lat + 1 : TO + 2);
        chk("rsp_id", rsp_id, id);
        chk("rsp_result", rsp_result, exp);
        chk("rsp_err", rsp_err, exp_err);
        chk("mul_a held", mul_a, a);
        chk("mul_b held", mul_b, b);
        chk("start pulses", starts - s0, 1);
        @(negedge clk);
        chk("rsp_valid drop", rsp_valid, 0);
    endtask

    task automatic drain();
        int n;
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        bit          en;
        bit          err;
    } vec_t;

    vec_t v[7];

    initial begin
        int n;
        bit seen_done, seen_rsp;
        v[0] = '{0, 32'd553524, 32'd840, 64'd464960160, 16, 1'b1, 1'b0};
        v[1] = '{2, -32'sd259, -32'sd259, 64'd67081, 5, 1'b1, 1'b0};
        v[2] = '{1, -32'sd259, 32'd553524, -64'sd143362716, 4, 1'b1, 1'b0};
        v[3] = '{3, 32'hFFFF_FFFF, 32'h8000_0000, 64'd2147483648, 2, 1'b1, 1'b0};
        v[4] = '{0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 3, 1'b1, 1'b0};
        v[5] = '{1, 32'd5, 32'd7, 64'd0, 16, 1'b0, 1'b1};
        v[6] = '{2, 32'd1, 32'd1348760118, 64'd1348760118, 6, 1'b1, 1'b0};

        reset = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("reset outputs", {req_ready, mul_start, rsp_valid, rsp_err, timeout_err, rsp_id}, 0);
        chk("reset result", rsp_result, 0);
        chk("reset mul_a", mul_a, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 7; i++)
            run_op(v[i].id, v[i].a, v[i].b, v[i].exp, v[i].lat, v[i].en, v[i].err);
        chk("timeout_err sticky", timeout_err, 1);

        // Round-robin order with all requesters asserted from reset.
        reset = 1'b1;
        model_en = 1'b1;
        model_lat = 3;
        req_a = {32'd5, 32'd4, 32'd3, 32'd2};
        req_b = {4{32'hFFFF_FFFD}};
        req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("timeout_err cleared", timeout_err, 0);
        for (int i = 0; i < 6; i++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (req_ready == 0 && n < 30);
            chk("rr grant", req_ready, 4'(1) << (i % 4));
            @(negedge clk);
            chk("rr pulse width", req_ready, 0);
        end
        drain();

        // Response backpressure: next grant must be 0 (after last grant 1).
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 4'b0011;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
        chk("bp rsp_id", rsp_id, 0);
        chk("bp result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFA);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp hold", {rsp_valid, rsp_id, req_ready, mul_start}, {1'b1, 2'd0, 4'b0000, 1'b0});
            chk("bp result held", rsp_result, 64'hFFFF_FFFF_FFFF_FFFA);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp next grant", req_ready, 4'b0010);
        drain();

        // Reset in the middle of WAIT, then a stale done from the model.
        @(posedge clk); #1;
        model_lat = 30;
        req_valid = 4'b0100;
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == 0 && n < 20);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset outputs", {req_ready, mul_start, rsp_valid, rsp_err, timeout_err, rsp_id}, 0);
        chk("mid reset mul_a", mul_a, 0);
        chk("mid reset result", rsp_result, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen_done = 1'b0;
        seen_rsp = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (mul_done) seen_done = 1'b1;
            if (rsp_valid || mul_start) seen_rsp = 1'b1;
        end
        chk("late done seen", seen_done, 1);
        chk("no rsp after reset", seen_rsp, 0);
        @(posedge clk); #1;
        model_lat = 2;
        req_valid = 4'b1111;
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == 0 && n < 20);
        chk("post reset grant", req_ready, 4'b0001);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_rr_scheduler.md
Name: mul_rr_scheduler

Overview:
Round-robin scheduler that shares one multi-cycle signed multiplier between NUM_REQ requesters. It accepts operand pairs over a valid/ready handshake and issues one start pulse per operation. It waits for the multiplier's done, then returns the 2*WIDTH signed product tagged with the requester id. It sits between client units and the shared multiplier datapath, and it guards against a hung multiplier with a watchdog.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand width; products are 2*WIDTH bits, signed
TIMEOUT_CYCLES, 64, maximum WAIT cycles before the operation is aborted

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester operation request
req_ready  output  NUM_REQ  one-hot acceptance pulse
req_a  input  NUM_REQ*WIDTH  packed signed operand A; slice i belongs to requester i
req_b  input  NUM_REQ*WIDTH  packed signed operand B
mul_a  output  WIDTH  latched operand A to the multiplier
mul_b  output  WIDTH  latched operand B to the multiplier
mul_start  output  1  one-cycle start pulse
mul_done  input  1  multiplier completion strobe
mul_result  input  2*WIDTH  multiplier product, valid while mul_done=1
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts the response
rsp_id  output  clog2(NUM_REQ)  id of the requester that was served
rsp_result  output  2*WIDTH  signed product; 0 on timeout
rsp_err  output  1  response was aborted by the watchdog
timeout_err  output  1  sticky watchdog flag; cleared only by reset

Behaviour:
- Reset values: all outputs 0, FSM=IDLE, watchdog counter 0, round-robin pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
- A reset assertion in any state aborts the operation immediately. No response is produced for an aborted operation.
- IDLE:
  - If any req_valid is high, grant g is the first asserted index searching from last_grant+1 upward, with modulo wrap.
  - req_ready[g]=1 combinationally in that cycle only. req_ready is never asserted outside IDLE.
  - On that edge: latch mul_a/mul_b from slice g, latch the grant id, set last_grant=g, go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE: mul_start=1 for exactly this cycle, clear the watchdog, go to WAIT.
- WAIT:
  - mul_start=0 and mul_a/mul_b are held stable.
  - If mul_done=1: capture mul_result into rsp_result, set rsp_err=0, go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES without done: set rsp_result=0, rsp_err=1, timeout_err=1, go to RESP.
  - If mul_done is high on the same cycle the watchdog would expire, done wins.
- RESP:
  - rsp_valid=1. rsp_id, rsp_result and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake edge, go to IDLE and drop rsp_valid the next cycle.
  - No new grant is made while in RESP.
- mul_done in IDLE, ISSUE or RESP is ignored. A late done after a timeout must not corrupt the next operation's state.
- Latency: request handshake at edge T, mul_start high in cycle T+1. If done arrives in WAIT cycle D, rsp_valid is high from D+1. With rsp_ready tied high, the next grant is possible 1 cycle after the response handshake.
- Maximum throughput is one operation per (multiplier latency + 3) cycles. There is no pipelining of multiple operations.
- Arithmetic: the block performs no arithmetic on operands. The product passes through at full 2*WIDTH width with its sign preserved.
- A requester whose req_valid drops before its grant simply loses its turn; the pointer is unchanged.

Test Plan:
- Single request from requester 0 with a=553524, b=840; the multiplier model returns after 16 cycles -> one mul_start pulse, rsp_id=0, rsp_result=464960160, rsp_err=0, rsp_valid 17 cycles after the handshake.
- Requester 2 with a=-259, b=-259 -> rsp_id=2, rsp_result=67081. Then requester 1 with a=-259, b=553524 -> rsp_result=-143362716 sign-extended to 64 bits.
- All four req_valid held high from reset, rsp_ready=1 -> grant order 0,1,2,3,0,1. Each req_ready pulse is one cycle wide and one-hot.
- rsp_ready held low for 5 cycles after rsp_valid -> rsp_result and rsp_id stay stable, req_ready stays 0, mul_start is not pulsed. The grant proceeds after rsp_ready rises.
- Multiplier model never asserts done -> after 64 WAIT cycles rsp_valid=1 with rsp_err=1, rsp_result=0, and timeout_err stays 1. A next operation with a=1, b=1348760118 then completes with rsp_result=1348760118 and rsp_err=0.
- reset asserted mid-WAIT, then a late mul_done pulse after reset deasserts -> all outputs 0, no rsp_valid, FSM in IDLE, and the next grant goes to requester 0.
